arith_arbiter: RTL and testbench

ARITH_ARBITER -- requirements
Module: arith_arbiter

---
 rtl/arith_pkg.sv | 25 ++
 rtl/arith_arbiter_if.sv | 40 ++++
 rtl/arith_core.sv | 52 +++++
 rtl/arith_arbiter.sv | 120 ++++++++++++
 tb/tb_arith_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the two-requester arithmetic arbiter:
//   WIDTH          operand / result width
//   DEC/ADD/SUB/NEG op-codes {S1,S0}
//   state_t        arbiter FSM state encoding
// -----------------------------------------------------------------------------
package arith_pkg;

    localparam int WIDTH = 3;

    typedef logic [1:0] op_t;

    localparam op_t DEC = 2'b00;  // A + 111
    localparam op_t ADD = 2'b01;  // A + B
    localparam op_t SUB = 2'b10;  // A + ~B + 1
    localparam op_t NEG = 2'b11;  // 0 + ~B + 1

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/arith_arbiter_if.sv
// -----------------------------------------------------------------------------
// arith_arbiter_if
// Request/response bundle of arith_arbiter.
//   req_valid/req_ready     per-requester handshake (bit i = requester i)
//   req_a*/req_b*/req_op*   operands and op-code of each requester
//   rsp_valid/rsp_ready     result handshake
//   rsp_id/g/carry/ovf      result owner and result fields
//   busy                    arbiter FSM not idle
// master: requesters + result consumer; slave: the arbiter.
// -----------------------------------------------------------------------------
interface arith_arbiter_if;
    import arith_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    op_t              req_op0;
    op_t              req_op1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_g;
    logic             rsp_carry;
    logic             rsp_ovf;
    logic             busy;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_g, rsp_carry, rsp_ovf, busy
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_g, rsp_carry, rsp_ovf, busy
    );

endinterface

// File: rtl/arith_core.sv
// -----------------------------------------------------------------------------
// arith_core
// Combinational 3-bit datapath: every op is folded onto one adder x + y + cin.
//   a, b   two's-complement operands
//   op     op-code (DEC/ADD/SUB/NEG)
//   g      sum bits
//   carry  carry-out of the top bit
//   ovf    signed overflow (adder operands agree in sign, sum does not)
// -----------------------------------------------------------------------------
module arith_core
    import arith_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] g,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_x   = a;
        w_y   = b;
        w_cin = 1'b0;
        case (op)
            DEC: w_y = '1;
            ADD: w_y = b;
            SUB: begin
                w_y   = ~b;
                w_cin = 1'b1;
            end
            NEG: begin
                w_x   = '0;
                w_y   = ~b;
                w_cin = 1'b1;
            end
            default: w_y = b;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    assign g     = w_sum[WIDTH-1:0];
    assign carry = w_sum[WIDTH];
    // Overflow is judged on the adder operands (after inversion), not on a/b.
    assign ovf   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (g[WIDTH-1] != w_x[WIDTH-1]);

endmodule

// File: rtl/arith_arbiter.sv
// -----------------------------------------------------------------------------
// arith_arbiter
// Round-robin arbiter in front of a single arith_core. One operation in flight:
// IDLE accepts a request, EXEC computes and registers the result, RESP holds it
// until the consumer takes it.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   arith_arbiter_if.slave (request/response handshakes, busy)
// -----------------------------------------------------------------------------
module arith_arbiter
    import arith_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    arith_arbiter_if.slave bus
);

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    op_t              r_op;
    logic             r_id;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_g;
    logic             r_rsp_carry;
    logic             r_rsp_ovf;

    logic [1:0]       w_grant;
    logic [1:0]       w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_g;
    logic             w_carry;
    logic             w_ovf;

    // One-hot grant from the current valids; on a tie the requester that
    // did not win last time goes first.
    always_comb begin
        w_grant = 2'b00;
        case (bus.req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_ready  = 2'b00;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready  = w_grant;
                w_accept = |(bus.req_valid & w_grant);
                if (w_accept) w_next = ST_EXEC;
            end
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    arith_core u_core (
        .a     (r_a),
        .b     (r_b),
        .op    (r_op),
        .g     (w_g),
        .carry (w_carry),
        .ovf   (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= DEC;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_g      <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant[1];
                r_id         <= w_grant[1];
                r_a          <= w_grant[1] ? bus.req_a1  : bus.req_a0;
                r_b          <= w_grant[1] ? bus.req_b1  : bus.req_b0;
                r_op         <= w_grant[1] ? bus.req_op1 : bus.req_op0;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_g     <= w_g;
                r_rsp_carry <= w_carry;
                r_rsp_ovf   <= w_ovf;
            end else if (r_state == ST_RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_g     = r_rsp_g;
    assign bus.rsp_carry = r_rsp_carry;
    assign bus.rsp_ovf   = r_rsp_ovf;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_arith_arbiter.sv
// -----------------------------------------------------------------------------
// tb_arith_arbiter
// Directed vectors with hand-computed results. Inputs change on the falling
// edge; outputs are sampled on the falling edge or 1 ns after an input change.
// -----------------------------------------------------------------------------
module tb_arith_arbiter;
    import arith_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arith_arbiter_if bus ();

    arith_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "/rdy"},   {6'd0, bus.req_ready}, 8'h00);
        chk({tag, "/busy"},  {7'd0, bus.busy},      8'h00);
        chk({tag, "/vld"},   {7'd0, bus.rsp_valid}, 8'h00);
        chk({tag, "/id"},    {7'd0, bus.rsp_id},    8'h00);
        chk({tag, "/g"},     {5'd0, bus.rsp_g},     8'h00);
        chk({tag, "/carry"}, {7'd0, bus.rsp_carry}, 8'h00);
        chk({tag, "/ovf"},   {7'd0, bus.rsp_ovf},   8'h00);
    endtask

    // One request from an idle start; operands are scrambled after accept so
    // a result that depends on the live inputs shows up as wrong.
    task automatic single(input string tag, input logic id,
                          input logic [2:0] a, input logic [2:0] b, input op_t op,
                          input logic [2:0] eg, input logic ec, input logic eo);
        @(negedge clk);
        if (id) begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; bus.req_valid = 2'b10;
        end else begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; bus.req_valid = 2'b01;
        end
        #1 chk({tag, "/rdy"}, {6'd0, bus.req_ready}, id ? 8'h02 : 8'h01);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.req_a0 = ~a; bus.req_a1 = ~a; bus.req_b0 = ~b; bus.req_b1 = ~b;
        bus.req_op0 = ~op; bus.req_op1 = ~op;
        chk({tag, "/exec_busy"}, {7'd0, bus.busy},      8'h01);
        chk({tag, "/exec_vld"},  {7'd0, bus.rsp_valid}, 8'h00);
        @(negedge clk);
        chk({tag, "/vld"},   {7'd0, bus.rsp_valid}, 8'h01);
        chk({tag, "/id"},    {7'd0, bus.rsp_id},    {7'd0, id});
        chk({tag, "/g"},     {5'd0, bus.rsp_g},     {5'd0, eg});
        chk({tag, "/carry"}, {7'd0, bus.rsp_carry}, {7'd0, ec});
        chk({tag, "/ovf"},   {7'd0, bus.rsp_ovf},   {7'd0, eo});
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "/done_busy"}, {7'd0, bus.busy},      8'h00);
        chk({tag, "/done_vld"},  {7'd0, bus.rsp_valid}, 8'h00);
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = DEC;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = DEC;
        bus.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;

        single("add_ovf", 1'b0, 3'b011, 3'b001, ADD, 3'b100, 1'b0, 1'b1);
        single("sub",     1'b1, 3'b001, 3'b010, SUB, 3'b111, 1'b0, 1'b0);
        single("dec",     1'b0, 3'b000, 3'b101, DEC, 3'b111, 1'b0, 1'b0);
        single("neg",     1'b1, 3'b110, 3'b011, NEG, 3'b101, 1'b0, 1'b0);
        single("add_cy",  1'b0, 3'b101, 3'b101, ADD, 3'b010, 1'b1, 1'b1);

        // Round robin: both valid, consumer always ready, starting from reset.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.req_a0 = 3'b001; bus.req_b0 = 3'b001; bus.req_op0 = ADD;  // -> 010
        bus.req_a1 = 3'b010; bus.req_b1 = 3'b011; bus.req_op1 = ADD;  // -> 101
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        #1 chk("rr/rdy0", {6'd0, bus.req_ready}, 8'h01);
        for (int c = 1; c < 12; c++) begin
            @(negedge clk);
            if (c % 3 == 0)
                chk($sformatf("rr/rdy%0d", c), {6'd0, bus.req_ready}, ((c / 3) % 2 == 1) ? 8'h02 : 8'h01);
            else
                chk($sformatf("rr/rdy%0d", c), {6'd0, bus.req_ready}, 8'h00);
            if (c % 3 == 2) begin
                chk($sformatf("rr/id%0d", c), {7'd0, bus.rsp_id}, ((c / 3) % 2 == 1) ? 8'h01 : 8'h00);
                chk($sformatf("rr/g%0d", c),  {5'd0, bus.rsp_g},  ((c / 3) % 2 == 1) ? 8'h05 : 8'h02);
            end
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Backpressure: requester 1 SUB 011 - 001 = 010, carry 1, ovf 0.
        bus.req_a1 = 3'b011; bus.req_b1 = 3'b001; bus.req_op1 = SUB;
        bus.req_valid = 2'b10;
        #1 chk("bp/rdy", {6'd0, bus.req_ready}, 8'h02);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("bp/vld", {7'd0, bus.rsp_valid}, 8'h01);
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = 2'b11;
            bus.req_a0 = 3'(k); bus.req_b0 = 3'(k + 3); bus.req_op0 = op_t'(k);
            bus.req_a1 = 3'(k + 1); bus.req_b1 = 3'(k + 5); bus.req_op1 = op_t'(k + 1);
            @(negedge clk);
            chk($sformatf("bp/vld%0d", k),   {7'd0, bus.rsp_valid}, 8'h01);
            chk($sformatf("bp/id%0d", k),    {7'd0, bus.rsp_id},    8'h01);
            chk($sformatf("bp/g%0d", k),     {5'd0, bus.rsp_g},     8'h02);
            chk($sformatf("bp/carry%0d", k), {7'd0, bus.rsp_carry}, 8'h01);
            chk($sformatf("bp/ovf%0d", k),   {7'd0, bus.rsp_ovf},   8'h00);
            chk($sformatf("bp/rdy%0d", k),   {6'd0, bus.req_ready}, 8'h00);
            chk($sformatf("bp/busy%0d", k),  {7'd0, bus.busy},      8'h01);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp/idle_busy", {7'd0, bus.busy},      8'h00);
        chk("bp/idle_vld",  {7'd0, bus.rsp_valid}, 8'h00);

        // Reset while in EXEC (accepted requester 0, so without a reset the
        // next tie would go to requester 1).
        bus.req_a0 = 3'b011; bus.req_b0 = 3'b001; bus.req_op0 = ADD;
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("rx/exec_busy", {7'd0, bus.busy}, 8'h01);
        rst = 1'b1;
        #1 chk_reset_outs("rx");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rx/post_vld%0d", k),  {7'd0, bus.rsp_valid}, 8'h00);
            chk($sformatf("rx/post_busy%0d", k), {7'd0, bus.busy},      8'h00);
        end
        bus.req_valid = 2'b11;
        #1 chk("rx/tie_rdy", {6'd0, bus.req_ready}, 8'h01);
        @(negedge clk);
        bus.req_valid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
